// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transfer sequencer.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        XFER  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam int SPI_BITS = 8;
    localparam int EDGE_W   = $clog2(2 * SPI_BITS);

    typedef struct packed {
        logic drive;
        logic sample;
    } strobe_t;

    // e0 is the edge index LSB (0 = leading edge); the final trailing edge never drives.
    function automatic strobe_t edge_strobes(input logic e0, input logic cpha, input logic last);
        strobe_t s;
        if (cpha) begin
            s.drive  = ~e0;
            s.sample = e0;
        end else begin
            s.sample = ~e0;
            s.drive  = e0 & ~last;
        end
        return s;
    endfunction

endpackage

// File: rtl/spi_baud_counter.sv
// Half-period down-counter with reload; tc marks the last cycle of a half period.
module spi_baud_counter #(
    parameter int DIV_W = 12
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tc,
    output logic             tc_next
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nxt_s;

    // Next count: reload, count down, or park at zero.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = load_val;
        end else if (cnt_r != {DIV_W{1'b0}}) begin
            cnt_nxt_s = cnt_r - DIV_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
        tc_next = (cnt_nxt_s == {DIV_W{1'b0}});
    end

    // Counter and registered terminal count.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_r <= {DIV_W{1'b0}};
            tc    <= 1'b1;
        end else begin
            cnt_r <= cnt_nxt_s;
            tc    <= tc_next;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Master-mode SPI transfer sequencer: SCLK generation, slave select and shift-register strobes.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DIV_W = 12,
    parameter int BITS  = SPI_BITS
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             spe,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sclk,
    output logic             ss,
    output logic             send_data,
    output logic             flags_high,
    output logic             flag_high,
    output logic             receive_data,
    output logic             busy,
    output logic             done
);

    localparam int             EW     = $clog2(2 * BITS);
    localparam logic [EW-1:0]  LAST_E = EW'(2 * BITS - 1);

    state_t           state_r;
    logic [EW-1:0]    edge_r;
    logic [DIV_W-1:0] div_r;
    logic             cpol_r;
    logic             cpha_r;

    logic             load_s;
    logic [DIV_W-1:0] load_val_s;
    logic             tc_s;
    logic             tc_next_s;
    logic [EW-1:0]    edge_inc_s;
    strobe_t          strb_cur_s;
    strobe_t          strb_inc_s;
    strobe_t          strb_first_s;

    assign load_s     = (state_r == LOAD) || (tc_s && ((state_r == SETUP) || (state_r == XFER)));
    assign load_val_s = (state_r == LOAD) ? div : div_r;
    assign edge_inc_s = edge_r + EW'(1);

    // Strobes are registered one cycle ahead, so decode the edge the next cycle will close.
    assign strb_cur_s   = edge_strobes(edge_r[0], cpha_r, edge_r == LAST_E);
    assign strb_inc_s   = edge_strobes(edge_inc_s[0], cpha_r, edge_inc_s == LAST_E);
    assign strb_first_s = edge_strobes(1'b0, cpha_r, 1'b0);

    spi_baud_counter #(.DIV_W(DIV_W)) u_baud (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .load     (load_s),
        .load_val (load_val_s),
        .tc       (tc_s),
        .tc_next  (tc_next_s)
    );

    // Transfer FSM with registered SCLK, slave select and strobes.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r      <= IDLE;
            edge_r       <= {EW{1'b0}};
            div_r        <= {DIV_W{1'b0}};
            cpol_r       <= 1'b0;
            cpha_r       <= 1'b0;
            sclk         <= 1'b0;
            ss           <= 1'b1;
            busy         <= 1'b0;
            send_data    <= 1'b0;
            flags_high   <= 1'b0;
            flag_high    <= 1'b0;
            receive_data <= 1'b0;
            done         <= 1'b0;
        end else begin
            send_data    <= 1'b0;
            flags_high   <= 1'b0;
            flag_high    <= 1'b0;
            receive_data <= 1'b0;
            done         <= 1'b0;
            if ((state_r != IDLE) && !spe) begin
                state_r <= IDLE;
                ss      <= 1'b1;
                sclk    <= cpol;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        ss   <= 1'b1;
                        sclk <= cpol;
                        busy <= 1'b0;
                        if (start && spe) begin
                            state_r   <= LOAD;
                            send_data <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    LOAD: begin
                        div_r      <= div;
                        cpol_r     <= cpol;
                        cpha_r     <= cpha;
                        edge_r     <= {EW{1'b0}};
                        ss         <= 1'b0;
                        sclk       <= cpol;
                        flags_high <= ~cpha;
                        state_r    <= SETUP;
                    end
                    SETUP: begin
                        if (tc_s) begin
                            state_r    <= XFER;
                            flags_high <= tc_next_s & strb_first_s.drive;
                            flag_high  <= tc_next_s & strb_first_s.sample;
                        end
                    end
                    XFER: begin
                        if (tc_s) begin
                            if (edge_r == LAST_E) begin
                                state_r      <= HOLD;
                                sclk         <= cpol_r;
                                done         <= tc_next_s;
                                receive_data <= tc_next_s;
                            end else begin
                                sclk       <= ~sclk;
                                edge_r     <= edge_inc_s;
                                flags_high <= tc_next_s & strb_inc_s.drive;
                                flag_high  <= tc_next_s & strb_inc_s.sample;
                            end
                        end else begin
                            flags_high <= tc_next_s & strb_cur_s.drive;
                            flag_high  <= tc_next_s & strb_cur_s.sample;
                        end
                    end
                    HOLD: begin
                        if (tc_s) begin
                            state_r <= IDLE;
                            ss      <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            done         <= tc_next_s;
                            receive_data <= tc_next_s;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        ss      <= 1'b1;
                        sclk    <= cpol;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed, table-driven bench for spi_xfer_ctrl.
module tb_spi_xfer_ctrl;

    logic        PCLK;
    logic        PRESETn;
    logic        spe;
    logic        start;
    logic [11:0] div;
    logic        cpol;
    logic        cpha;
    logic        sclk;
    logic        ss;
    logic        send_data;
    logic        flags_high;
    logic        flag_high;
    logic        receive_data;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    spi_xfer_ctrl #(.DIV_W(12), .BITS(8)) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .spe          (spe),
        .start        (start),
        .div          (div),
        .cpol         (cpol),
        .cpha         (cpha),
        .sclk         (sclk),
        .ss           (ss),
        .send_data    (send_data),
        .flags_high   (flags_high),
        .flag_high    (flag_high),
        .receive_data (receive_data),
        .busy         (busy),
        .done         (done)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int send_cyc;
        int n_send;
        int ss_low_cyc;
        int done_cyc;
        int n_done;
        int n_sample;
        int n_drive;
        int n_toggle;
        int n_level_err;
        int n_rx_err;
        int abort_cyc;
        int ss_after;
        int sclk_after;
        int busy_after;
        int strb_after;
    } res_t;

    typedef struct {
        logic [11:0] d;
        logic        pol;
        logic        pha;
        int          exp_done_cyc;
        int          exp_ss_low;
        int          exp_pulses;
        int          exp_toggles;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start one transfer (start in cycle 0) and monitor it on falling edges.
    task automatic run_xfer(input logic [11:0] d, input logic pol, input logic pha,
                            input int abort_edges, input bit extra_starts, input bit cfg_change,
                            output res_t r);
        logic prev_sclk;
        r = '{default: 0};
        div  = d;
        cpol = pol;
        cpha = pha;
        spe  = 1'b1;
        @(negedge PCLK);
        prev_sclk = sclk;
        start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge PCLK);
            start = 1'b0;
            if (extra_starts && (k == 3 || k == 12)) start = 1'b1;
            if (cfg_change && k == 10) begin
                div  = 12'd3;
                cpha = ~pha;
            end
            if (r.abort_cyc != 0 && k == r.abort_cyc + 1) begin
                r.ss_after   = ss;
                r.sclk_after = sclk;
                r.busy_after = busy;
                r.strb_after = int'(flag_high) + int'(flags_high) + int'(send_data) + int'(done) + int'(receive_data);
                break;
            end
            if (send_data) begin
                r.n_send++;
                if (r.send_cyc == 0) r.send_cyc = k;
            end
            if (!ss && r.ss_low_cyc == 0) r.ss_low_cyc = k;
            if (flag_high) begin
                r.n_sample++;
                if (sclk != (pol ^ pha)) r.n_level_err++;
            end
            if (flags_high) begin
                r.n_drive++;
                if (!(r.n_drive == 1 && !pha) && sclk != ~(pol ^ pha)) r.n_level_err++;
            end
            if (receive_data != done) r.n_rx_err++;
            if (sclk != prev_sclk) r.n_toggle++;
            prev_sclk = sclk;
            if (abort_edges > 0 && r.n_toggle == abort_edges && spe) begin
                spe = 1'b0;
                r.abort_cyc = k;
            end
            if (r.done_cyc != 0 && k == r.done_cyc + 1) begin
                r.ss_after   = ss;
                r.busy_after = busy;
                break;
            end
            if (done) begin
                r.n_done++;
                r.done_cyc = k;
            end
        end
        start = 1'b0;
        spe   = 1'b1;
    endtask

    vec_t vecs[5];
    res_t r;
    int   cnt;

    initial begin
        PRESETn = 1'b0;
        spe     = 1'b0;
        start   = 1'b0;
        div     = 12'd0;
        cpol    = 1'b1;
        cpha    = 1'b0;

        // done cycle = 1 + (2*BITS+2)*(div+1), counted from the start cycle
        vecs[0] = '{12'd1, 1'b0, 1'b0, 37, 2, 8, 16};
        vecs[1] = '{12'd0, 1'b1, 1'b1, 19, 2, 8, 16};
        vecs[2] = '{12'd2, 1'b0, 1'b1, 55, 2, 8, 16};
        vecs[3] = '{12'd0, 1'b0, 1'b0, 19, 2, 8, 16};
        vecs[4] = '{12'd3, 1'b1, 1'b0, 73, 2, 8, 16};

        repeat (3) @(negedge PCLK);
        check("rst_ss", ss, 1);
        check("rst_sclk", sclk, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", int'(send_data) + int'(flags_high) + int'(flag_high) + int'(done) + int'(receive_data), 0);

        PRESETn = 1'b1;
        cpol = 1'b0;
        repeat (2) @(negedge PCLK);
        check("idle_ss", ss, 1);
        check("idle_sclk", sclk, 0);
        cpol = 1'b1;
        repeat (2) @(negedge PCLK);
        check("idle_tracks_cpol", sclk, 1);
        cpol = 1'b0;

        // start with spe low must be ignored
        spe = 1'b0;
        start = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge PCLK);
            start = 1'b0;
            if (send_data || busy) cnt++;
        end
        check("spe_low_start", cnt, 0);
        spe = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i].d, vecs[i].pol, vecs[i].pha, 0, 1'b0, 1'b0, r);
            check($sformatf("v%0d_send_cyc", i), r.send_cyc, 1);
            check($sformatf("v%0d_n_send", i), r.n_send, 1);
            check($sformatf("v%0d_ss_low", i), r.ss_low_cyc, vecs[i].exp_ss_low);
            check($sformatf("v%0d_done_cyc", i), r.done_cyc, vecs[i].exp_done_cyc);
            check($sformatf("v%0d_n_done", i), r.n_done, 1);
            check($sformatf("v%0d_samples", i), r.n_sample, vecs[i].exp_pulses);
            check($sformatf("v%0d_drives", i), r.n_drive, vecs[i].exp_pulses);
            check($sformatf("v%0d_toggles", i), r.n_toggle, vecs[i].exp_toggles);
            check($sformatf("v%0d_edge_level", i), r.n_level_err, 0);
            check($sformatf("v%0d_rx_eq_done", i), r.n_rx_err, 0);
            check($sformatf("v%0d_ss_after", i), r.ss_after, 1);
            check($sformatf("v%0d_busy_after", i), r.busy_after, 0);
        end

        // abort after the 5th sclk edge
        run_xfer(12'd1, 1'b0, 1'b0, 5, 1'b0, 1'b0, r);
        check("abort_seen", (r.abort_cyc != 0) ? 1 : 0, 1);
        check("abort_ss", r.ss_after, 1);
        check("abort_sclk", r.sclk_after, 0);
        check("abort_busy", r.busy_after, 0);
        check("abort_strobes", r.strb_after, 0);
        check("abort_no_done", r.n_done, 0);
        run_xfer(12'd1, 1'b0, 1'b0, 0, 1'b0, 1'b0, r);
        check("post_abort_done", r.done_cyc, 37);
        check("post_abort_samples", r.n_sample, 8);

        // start pulses in SETUP and XFER are ignored
        run_xfer(12'd1, 1'b0, 1'b0, 0, 1'b1, 1'b0, r);
        check("busy_start_n_send", r.n_send, 1);
        check("busy_start_n_done", r.n_done, 1);
        check("busy_start_done", r.done_cyc, 37);

        // config change mid-XFER leaves the running transfer alone
        run_xfer(12'd1, 1'b0, 1'b0, 0, 1'b0, 1'b1, r);
        check("cfg_done", r.done_cyc, 37);
        check("cfg_samples", r.n_sample, 8);
        check("cfg_drives", r.n_drive, 8);
        check("cfg_level", r.n_level_err, 0);
        check("cfg_ss_low", r.ss_low_cyc, 2);
        run_xfer(div, cpol, cpha, 0, 1'b0, 1'b0, r);
        check("cfg_next_done", r.done_cyc, 73);
        check("cfg_next_level", r.n_level_err, 0);

        // reset mid-XFER
        div = 12'd1;
        cpol = 1'b1;
        cpha = 1'b0;
        @(negedge PCLK);
        start = 1'b1;
        @(negedge PCLK);
        start = 1'b0;
        repeat (10) @(negedge PCLK);
        check("pre_rst_busy", busy, 1);
        PRESETn = 1'b0;
        #1;
        check("mid_rst_ss", ss, 1);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_strobes", int'(send_data) + int'(flags_high) + int'(flag_high) + int'(done) + int'(receive_data), 0);
        repeat (2) @(negedge PCLK);
        check("hold_rst_sclk", sclk, 0);
        PRESETn = 1'b1;
        run_xfer(12'd1, 1'b1, 1'b0, 0, 1'b0, 1'b0, r);
        check("post_rst_done", r.done_cyc, 37);
        check("post_rst_samples", r.n_sample, 8);
        check("post_rst_toggles", r.n_toggle, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
